// File: rtl/serial_word_collector_if.sv
// Output-side bundle of serial_word_collector: assembled word with a valid/ready handshake.
interface serial_word_collector_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output par_out, output out_valid, input out_ready);
  modport slave  (input par_out, input out_valid, output out_ready);
endinterface

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial bits into WIDTH-bit words and hands them to a
// one-entry valid/ready buffer; a word completing while the buffer is stalled is dropped.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       flush,
  serial_word_collector_if.master    out_if,
  output logic                       overflow,
  output logic [CNT_W-1:0]           word_count,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int              BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] par_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [CNT_W-1:0] word_count_r;
  logic             overflow_r;
  logic             sample_s;
  logic             done_s;
  logic             xfer_s;
  logic             load_s;
  logic             drop_s;

  assign out_if.par_out   = par_r;
  assign out_if.out_valid = (state_r == FULL);
  assign overflow         = overflow_r;
  assign word_count       = word_count_r;
  assign bit_cnt          = bit_cnt_r;

  // Per-edge strobes: sampling, word completion, handshake, buffer load or drop
  always_comb begin
    sample_s = bit_valid & ~flush;
    done_s   = sample_s & (bit_cnt_r == LAST_BIT);
    word_s   = {serial_in, shreg_r[WIDTH-1:1]};
    xfer_s   = (state_r == FULL) & out_if.out_ready;
    // A transfer on the completion edge frees the slot for the new word
    load_s   = done_s & ((state_r == EMPTY) | out_if.out_ready);
    drop_s   = done_s & (state_r == FULL) & ~out_if.out_ready;
  end

  // Buffer-occupancy next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (done_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (xfer_s && !done_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Buffer-occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register and bit counter; flush wins over a same-cycle bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
    end else if (flush) begin
      shreg_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
    end else if (bit_valid) begin
      shreg_r   <= word_s;
      bit_cnt_r <= done_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Output word, accepted-word counter and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r        <= {WIDTH{1'b0}};
      word_count_r <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      if (load_s) begin
        par_r        <= word_s;
        word_count_r <= word_count_r + CNT_W'(1);
      end else begin
        par_r        <= par_r;
        word_count_r <= word_count_r;
      end
      overflow_r <= overflow_r | drop_s;
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: expected words are queued as stimulus
// is issued and popped by a monitor on each observed transfer.
module tb_serial_word_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic        bit_valid;
  logic        flush;
  logic        overflow;
  logic [15:0] word_count;
  logic [2:0]  bit_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_w;

  serial_word_collector_if #(.WIDTH(8)) vif ();

  serial_word_collector #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .out_if     (vif.master),
    .overflow   (overflow),
    .word_count (word_count),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
  task automatic step(input logic b, input logic v, input logic f, input logic r);
    serial_in     = b;
    bit_valid     = v;
    flush         = f;
    vif.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] rdy);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, 1'b0, rdy[i]);
    end
  endtask

  // Scoreboard: inputs change only just after posedge, so mid-cycle values decide the next edge
  always @(negedge clk) begin
    if (!rst && vif.out_valid && vif.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $error("FAIL xfer_unexpected: observed %0h expected none", vif.par_out);
      end else begin
        exp_w = exp_q.pop_front();
        assert (vif.par_out === exp_w) else begin
          n_bad++;
          $error("FAIL xfer_word: observed %0h expected %0h", vif.par_out, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; vif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(vif.out_valid), 32'd0);
    chk("rst_par",   32'(vif.par_out),   32'd0);
    chk("rst_wc",    32'(word_count),    32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_bcnt",  32'(bit_cnt),       32'd0);

    // 1: basic word, sink always ready
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 8'hFF);
    chk("t1_valid", 32'(vif.out_valid), 32'd1);
    chk("t1_par",   32'(vif.par_out),   32'hA5);
    chk("t1_wc",    32'(word_count),    32'd1);
    chk("t1_ovf",   32'(overflow),      32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid_1cyc", 32'(vif.out_valid), 32'd0);

    // 2: same word with a gap after every bit; bit_cnt must hold across gaps
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'hA5;
      step(w[i], 1'b1, 1'b0, 1'b1);
      chk("t2_bcnt", 32'(bit_cnt), (i == 7) ? 32'd0 : 32'(i + 1));
      if (i == 7) begin
        chk("t2_par", 32'(vif.par_out), 32'hA5);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t2_bcnt_hold", 32'(bit_cnt), (i == 7) ? 32'd0 : 32'(i + 1));
    end
    chk("t2_valid", 32'(vif.out_valid), 32'd0);
    chk("t2_wc",    32'(word_count),    32'd2);

    // 4: second word completes on the handshake edge of the first
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_word(8'h11, 8'hFF);
    chk("t4_par1", 32'(vif.par_out), 32'h11);
    send_word(8'h22, 8'h80);
    chk("t4_valid", 32'(vif.out_valid), 32'd1);
    chk("t4_par2",  32'(vif.par_out),   32'h22);
    chk("t4_wc",    32'(word_count),    32'd4);
    chk("t4_ovf",   32'(overflow),      32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_drain", 32'(vif.out_valid), 32'd0);

    // 5: flush discards three stale bits and the flush-cycle bit
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_bcnt3", 32'(bit_cnt), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_bcnt0", 32'(bit_cnt), 32'd0);
    chk("t5_valid_nf", 32'(vif.out_valid), 32'd0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 8'hFF);
    chk("t5_par", 32'(vif.par_out), 32'h5A);
    chk("t5_wc",  32'(word_count),  32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_drain", 32'(vif.out_valid), 32'd0);

    // 3: backpressure; later words are dropped and overflow sticks
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 8'h00);
    chk("t3_par_a", 32'(vif.par_out), 32'h3C);
    chk("t3_ovf_a", 32'(overflow),    32'd0);
    send_word(8'hC3, 8'h00);
    chk("t3_par_b",   32'(vif.par_out),   32'h3C);
    chk("t3_valid_b", 32'(vif.out_valid), 32'd1);
    chk("t3_ovf_b",   32'(overflow),      32'd1);
    send_word(8'hFF, 8'h00);
    chk("t3_par_c", 32'(vif.par_out), 32'h3C);
    chk("t3_wc",    32'(word_count),  32'd6);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_valid_d", 32'(vif.out_valid), 32'd0);
    chk("t3_ovf_d",   32'(overflow),      32'd1);

    // 6: asynchronous reset with a held word, overflow set and a partial word
    send_word(8'h77, 8'h00);
    chk("t6_par77", 32'(vif.par_out), 32'h77);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_bcnt4", 32'(bit_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(vif.out_valid), 32'd0);
    chk("t6_par",   32'(vif.par_out),   32'd0);
    chk("t6_wc",    32'(word_count),    32'd0);
    chk("t6_ovf",   32'(overflow),      32'd0);
    chk("t6_bcnt",  32'(bit_cnt),       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(8'h0F);
    send_word(8'h0F, 8'hFF);
    chk("t6_par0f", 32'(vif.par_out), 32'h0F);
    chk("t6_wc1",   32'(word_count),  32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_drain", 32'(vif.out_valid), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
